// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: FSM encoding and ratio/period constants.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam int RATIO_W = 8;
    localparam logic [RATIO_W-1:0] PWM_PERIOD_MAX = 8'd254;

endpackage

// File: rtl/pwm_prescaler.sv
// Divides the clock into PWM count ticks; counter is held at zero whenever run is low.
module pwm_prescaler #(
    parameter int PRESCALE   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = '0;
        if (run && !tick) begin
            cnt_d = cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// 255-count PWM generator with period-aligned ratio updates and H-bridge dead time
// on direction reversal.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int PRESCALE     = 4,
    parameter int PRESCALE_W   = 8,
    parameter int DEAD_PERIODS = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pwm_enable,
    input  logic               pwm_update,
    input  logic [RATIO_W-1:0] pwm_ratio,
    input  logic               dir_req,
    output logic               pwm_done,
    output logic               pwm_out,
    output logic               motor_dir,
    output logic [RATIO_W-1:0] active_ratio,
    output logic               dead_active
);

    localparam int DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);

    state_t               state_q, state_d;
    logic [RATIO_W-1:0]   per_q, per_d;
    logic [DEAD_W-1:0]    dead_q, dead_d;
    logic [RATIO_W-1:0]   staged_q, staged_d;
    logic [RATIO_W-1:0]   active_q, active_d;
    logic                 pending_q, pending_d;
    logic                 done_q, done_d;
    logic                 out_q, out_d;
    logic                 dir_q, dir_d;

    logic run;
    logic tick;
    logic boundary;
    logic load_idle;
    logic load_run;

    assign run      = pwm_enable && (state_q != IDLE);
    assign boundary = tick && (per_q == PWM_PERIOD_MAX);

    pwm_prescaler #(
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        dead_d    = dead_q;
        dir_d     = dir_q;
        active_d  = active_q;
        pending_d = pending_q;
        staged_d  = pwm_update ? pwm_ratio : staged_q;

        // A live update coinciding with the boundary wins over the staged value.
        load_idle = (state_q == IDLE) && pending_q;
        load_run  = boundary && (pending_q || pwm_update);
        if (load_idle) begin
            active_d = staged_q;
        end else if (load_run) begin
            active_d = pwm_update ? pwm_ratio : staged_q;
        end
        done_d = load_idle || load_run;

        if (load_run) begin
            pending_d = 1'b0;
        end else if (pwm_update) begin
            pending_d = 1'b1;
        end else if (load_idle) begin
            pending_d = 1'b0;
        end

        out_d = pwm_enable && (state_q == RUN) && (active_q > per_q);

        if (state_q == IDLE) begin
            dir_d = dir_req;
        end

        if (!pwm_enable) begin
            state_d = IDLE;
            per_d   = '0;
            dead_d  = '0;
        end else begin
            if (tick) begin
                per_d = (per_q == PWM_PERIOD_MAX) ? '0 : per_q + RATIO_W'(1);
            end
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    per_d   = '0;
                end
                RUN: begin
                    // A zero ratio means the bridge is already off, so reverse at once.
                    if (boundary && (dir_req != dir_q)) begin
                        if (active_d != '0) begin
                            state_d = DEAD;
                            dead_d  = '0;
                        end else begin
                            dir_d = dir_req;
                        end
                    end
                end
                DEAD: begin
                    if (boundary) begin
                        if (dead_q == DEAD_LAST) begin
                            dir_d   = dir_req;
                            state_d = RUN;
                            dead_d  = '0;
                        end else begin
                            dead_d = dead_q + DEAD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            per_q     <= '0;
            dead_q    <= '0;
            staged_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            out_q     <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            dead_q    <= dead_d;
            staged_q  <= staged_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            out_q     <= out_d;
            dir_q     <= dir_d;
        end
    end

    assign pwm_done     = done_q;
    assign pwm_out      = out_q;
    assign motor_dir    = dir_q;
    assign active_ratio = active_q;
    assign dead_active  = (state_q == DEAD);

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: constant vector table, directed corner sequences and
// randomized traffic against a period-position reference model.
module tb_pwm_generator;

    localparam int P = 2;
    localparam int D = 2;
    localparam int T = 255 * P;

    logic       clock = 1'b0;
    logic       reset;
    logic       pwm_enable;
    logic       pwm_update;
    logic [7:0] pwm_ratio;
    logic       dir_req;
    logic       pwm_done;
    logic       pwm_out;
    logic       motor_dir;
    logic [7:0] active_ratio;
    logic       dead_active;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    pwm_generator #(
        .PRESCALE     (P),
        .PRESCALE_W   (8),
        .DEAD_PERIODS (D)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pwm_enable   (pwm_enable),
        .pwm_update   (pwm_update),
        .pwm_ratio    (pwm_ratio),
        .dir_req      (dir_req),
        .pwm_done     (pwm_done),
        .pwm_out      (pwm_out),
        .motor_dir    (motor_dir),
        .active_ratio (active_ratio),
        .dead_active  (dead_active)
    );

    // Reference model: position within the period is a single clock count 0..T-1.
    int         m_mode;   // 0 idle, 1 run, 2 dead
    int         m_pos;
    int         m_dead;
    logic [7:0] m_staged;
    logic [7:0] m_active;
    logic       m_pending;
    logic       m_dir;
    logic       m_done;
    logic       m_out;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_dead = 0;
        m_staged = 8'd0; m_active = 8'd0;
        m_pending = 1'b0; m_dir = 1'b0; m_done = 1'b0; m_out = 1'b0;
    endtask

    task automatic model_step();
        int         n_mode, n_pos, n_dead;
        logic [7:0] n_active;
        logic       n_pending, n_dir, do_load, bnd;
        n_mode = m_mode; n_pos = m_pos; n_dead = m_dead;
        n_active = m_active; n_pending = m_pending; n_dir = m_dir;
        do_load = 1'b0;
        bnd = (m_mode != 0) && pwm_enable && (m_pos == T - 1);
        if (m_mode == 0 && m_pending) begin
            do_load = 1'b1; n_active = m_staged;
        end else if (bnd && (m_pending || pwm_update)) begin
            do_load = 1'b1; n_active = pwm_update ? pwm_ratio : m_staged;
        end
        if (do_load && m_mode != 0) n_pending = 1'b0;
        else if (pwm_update)        n_pending = 1'b1;
        else if (do_load)           n_pending = 1'b0;
        if (m_mode == 0) n_dir = dir_req;
        if (!pwm_enable) begin
            n_mode = 0; n_pos = 0; n_dead = 0;
        end else if (m_mode == 0) begin
            n_mode = 1; n_pos = 0;
        end else begin
            n_pos = (m_pos + 1) % T;
            if (bnd && m_mode == 1 && dir_req != m_dir) begin
                if (n_active != 8'd0) begin n_mode = 2; n_dead = 0; end
                else n_dir = dir_req;
            end
            if (bnd && m_mode == 2) begin
                if (m_dead == D - 1) begin n_mode = 1; n_dead = 0; n_dir = dir_req; end
                else n_dead = m_dead + 1;
            end
        end
        m_out = pwm_enable && (m_mode == 1) && (int'(m_active) > m_pos / P);
        m_done = do_load;
        m_staged = pwm_update ? pwm_ratio : m_staged;
        m_mode = n_mode; m_pos = n_pos; m_dead = n_dead;
        m_active = n_active; m_pending = n_pending; m_dir = n_dir;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_bus();
        return {20'd0, pwm_out, pwm_done, motor_dir, dead_active, active_ratio};
    endfunction

    task automatic cyc();
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        #1;
        check("model", dut_bus(), {20'd0, m_out, m_done, m_dir, (m_mode == 2), m_active});
    endtask

    typedef struct {
        logic       en;
        logic       upd;
        logic [7:0] ratio;
        logic       dreq;
        int         cycles;
        logic       e_out;
        logic       e_done;
        logic       e_dir;
        logic       e_dead;
        logic [7:0] e_active;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, dn, c;
        logic en_r;

        tbl[0]  = '{1'b0, 1'b1, 8'd60,  1'b0, 1,              1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 8'd60,  1'b0, 1,              1'b0, 1'b1, 1'b0, 1'b0, 8'd60};
        tbl[2]  = '{1'b0, 1'b0, 8'd60,  1'b1, 1,              1'b0, 1'b0, 1'b1, 1'b0, 8'd60};
        tbl[3]  = '{1'b1, 1'b0, 8'd60,  1'b1, 1,              1'b0, 1'b0, 1'b1, 1'b0, 8'd60};
        tbl[4]  = '{1'b1, 1'b0, 8'd60,  1'b1, 1,              1'b1, 1'b0, 1'b1, 1'b0, 8'd60};
        tbl[5]  = '{1'b1, 1'b0, 8'd60,  1'b1, 60 * P - 1,     1'b1, 1'b0, 1'b1, 1'b0, 8'd60};
        tbl[6]  = '{1'b1, 1'b0, 8'd60,  1'b1, 1,              1'b0, 1'b0, 1'b1, 1'b0, 8'd60};
        tbl[7]  = '{1'b1, 1'b1, 8'd255, 1'b1, 1,              1'b0, 1'b0, 1'b1, 1'b0, 8'd60};
        tbl[8]  = '{1'b1, 1'b0, 8'd255, 1'b1, T - 60 * P - 2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd255};
        tbl[9]  = '{1'b1, 1'b0, 8'd255, 1'b1, 1,              1'b1, 1'b0, 1'b1, 1'b0, 8'd255};
        tbl[10] = '{1'b1, 1'b0, 8'd255, 1'b0, T - 1,          1'b1, 1'b0, 1'b1, 1'b1, 8'd255};
        tbl[11] = '{1'b1, 1'b0, 8'd255, 1'b0, 1,              1'b0, 1'b0, 1'b1, 1'b1, 8'd255};
        tbl[12] = '{1'b1, 1'b0, 8'd255, 1'b0, 2 * T - 1,      1'b0, 1'b0, 1'b0, 1'b0, 8'd255};
        tbl[13] = '{1'b1, 1'b0, 8'd255, 1'b0, 1,              1'b1, 1'b0, 1'b0, 1'b0, 8'd255};
        tbl[14] = '{1'b0, 1'b0, 8'd255, 1'b0, 1,              1'b0, 1'b0, 1'b0, 1'b0, 8'd255};
        tbl[15] = '{1'b0, 1'b1, 8'd0,   1'b0, 2,              1'b0, 1'b1, 1'b0, 1'b0, 8'd0};

        reset = 1'b1; pwm_enable = 1'b0; pwm_update = 1'b0; pwm_ratio = 8'd0; dir_req = 1'b0;
        model_reset();
        cyc();
        cyc();
        check("reset_outputs", dut_bus(), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            pwm_enable = tbl[i].en; pwm_update = tbl[i].upd;
            pwm_ratio  = tbl[i].ratio; dir_req = tbl[i].dreq;
            cyc();
            pwm_update = 1'b0;
            for (int k = 1; k < tbl[i].cycles; k++) cyc();
            check($sformatf("vec%0d", i), dut_bus(),
                  {20'd0, tbl[i].e_out, tbl[i].e_done, tbl[i].e_dir, tbl[i].e_dead, tbl[i].e_active});
        end

        // Ratio 128 from idle: loads at the first boundary, then 128 high counts per period.
        pwm_enable = 1'b1; pwm_update = 1'b1; pwm_ratio = 8'd128;
        cyc();
        pwm_update = 1'b0;
        c = 0;
        while (c < T + 2 && !pwm_done) begin cyc(); c++; end
        check("ratio128_done", {31'd0, pwm_done}, 32'd1);
        hi = 0;
        for (int k = 0; k < T; k++) begin cyc(); if (pwm_out) hi++; end
        check("ratio128_high", hi, 128 * P);
        check("ratio128_low", T - hi, 127 * P);

        // Three updates in one period: one pwm_done at the boundary, last one wins.
        dn = 0;
        for (int k = 1; k <= T + 2; k++) begin
            if (k == 10)  begin pwm_update = 1'b1; pwm_ratio = 8'd50;  end
            if (k == 100) begin pwm_update = 1'b1; pwm_ratio = 8'd100; end
            if (k == 300) begin pwm_update = 1'b1; pwm_ratio = 8'd200; end
            cyc();
            pwm_update = 1'b0;
            if (pwm_done) dn++;
        end
        check("multi_update_dones", dn, 1);
        check("multi_update_active", active_ratio, 8'd200);

        // Reversal reverted mid dead time: dead time runs out, direction stays.
        dir_req = 1'b1;
        c = 0;
        while (c < T && !dead_active) begin cyc(); c++; end
        check("revert_dead_entered", {31'd0, dead_active}, 32'd1);
        repeat (T / 2) cyc();
        dir_req = 1'b0;
        repeat (2 * T - T / 2 - 1) cyc();
        check("revert_dead_held", {31'd0, dead_active}, 32'd1);
        cyc();
        check("revert_dead_over", {31'd0, dead_active}, 32'd0);
        check("revert_dir_kept", {31'd0, motor_dir}, 32'd0);

        // Asynchronous reset in the middle of dead time.
        dir_req = 1'b1;
        c = 0;
        while (c < 2 * T && !dead_active) begin cyc(); c++; end
        check("reset_dead_entered", {31'd0, dead_active}, 32'd1);
        repeat (50) cyc();
        #2;
        reset = 1'b1;
        #1;
        check("reset_mid_dead", dut_bus(), 32'd0);
        model_reset();
        cyc();
        reset = 1'b0;
        pwm_enable = 1'b0;
        repeat (4) cyc();

        // Randomized traffic against the model.
        en_r = 1'b1;
        for (int n = 0; n < 20000; n++) begin
            if (en_r) en_r = ($urandom_range(1499) != 0);
            else      en_r = ($urandom_range(19) == 0);
            pwm_enable = en_r;
            pwm_update = ($urandom_range(249) == 0);
            case ($urandom_range(7))
                0:       pwm_ratio = 8'd0;
                1:       pwm_ratio = 8'd255;
                default: pwm_ratio = 8'($urandom_range(255));
            endcase
            if ($urandom_range(899) == 0) dir_req = ~dir_req;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
